// File: rtl/pixel_pkg.sv
// Shared pixel word layout and pack/unpack helpers for the pixel burst FIFO.
package pixel_pkg;

    localparam int PIX_W = 44;
    localparam int OVF_W = 16;

    localparam int X_LSB = 34;
    localparam int X_MSB = 43;
    localparam int Y_LSB = 24;
    localparam int Y_MSB = 33;
    localparam int R_LSB = 16;
    localparam int R_MSB = 23;
    localparam int G_LSB = 8;
    localparam int G_MSB = 15;
    localparam int B_LSB = 0;
    localparam int B_MSB = 7;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic logic [PIX_W-1:0] pack_pixel(input pixel_t p);
        logic [PIX_W-1:0] w;
        w = '0;
        w[X_MSB:X_LSB] = p.x;
        w[Y_MSB:Y_LSB] = p.y;
        w[R_MSB:R_LSB] = p.r;
        w[G_MSB:G_LSB] = p.g;
        w[B_MSB:B_LSB] = p.b;
        return w;
    endfunction

    function automatic pixel_t unpack_pixel(input logic [PIX_W-1:0] w);
        pixel_t p;
        p.x = w[X_MSB:X_LSB];
        p.y = w[Y_MSB:Y_LSB];
        p.r = w[R_MSB:R_LSB];
        p.g = w[G_MSB:G_LSB];
        p.b = w[B_MSB:B_LSB];
        return p;
    endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port pixel RAM: one write port, one read port with a registered output.
// The read register only loads on rd_en so the last word read stays on the output.
module pixel_fifo_ram
    import pixel_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = PIX_W
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage array write port; contents are not cleared by reset.
    always_ff @(posedge clk_25) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next read-register value: load on a read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Read output register, cleared so the downstream outputs start at zero.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_burst_fifo.sv
// Pixel burst FIFO: packs incoming pixels into 44-bit words, buffers them, flags
// burst readiness and counts pixels dropped while full (no upstream back-pressure).
module pixel_burst_fifo
    import pixel_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BURST_LEN = 8
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic              wrreq,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic [7:0]        red_i,
    input  logic [7:0]        green_i,
    input  logic [7:0]        blue_i,
    input  logic              rdreq,
    output logic              rd_valid,
    output logic [9:0]        x_o,
    output logic [9:0]        y_o,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic [ADDR_W:0]   usedw,
    output logic              empty,
    output logic              full,
    output logic              burst_rdy,
    output logic [OVF_W-1:0]  ovf_cnt
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int USEDW_W  = ADDR_W + 1;

    // Saturating increment for the dropped-pixel counter.
    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == {OVF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [ADDR_W-1:0]  wr_ptr_d,   wr_ptr_q;
    logic [ADDR_W-1:0]  rd_ptr_d,   rd_ptr_q;
    logic [USEDW_W-1:0] usedw_d,    usedw_q;
    logic [OVF_W-1:0]   ovf_cnt_d,  ovf_cnt_q;
    logic               rd_valid_d, rd_valid_q;

    logic               wr_acc;
    logic               rd_acc;
    logic               wr_ovf;
    logic [PIX_W-1:0]   wr_word;
    logic [PIX_W-1:0]   rd_word;
    pixel_t             wr_pix;
    pixel_t             rd_pix;

    // Flags come straight from the registered count, so they reflect the
    // state before this cycle's requests.
    assign empty     = (usedw_q == '0);
    assign full      = (usedw_q == USEDW_W'(DEPTH));
    assign burst_rdy = (usedw_q >= USEDW_W'(BURST_LEN));

    assign wr_acc = wrreq & ~full;
    assign rd_acc = rdreq & ~empty;
    assign wr_ovf = wrreq & full;

    assign wr_pix.x = x_i;
    assign wr_pix.y = y_i;
    assign wr_pix.r = red_i;
    assign wr_pix.g = green_i;
    assign wr_pix.b = blue_i;
    assign wr_word  = pack_pixel(wr_pix);

    // Next-state for pointers, occupancy, overflow counter and read strobe.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_cnt_d  = ovf_cnt_q;
        rd_valid_d = rd_acc;
        usedw_d    = usedw_q + USEDW_W'(wr_acc) - USEDW_W'(rd_acc);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_ovf) begin
            ovf_cnt_d = sat_inc(ovf_cnt_q);
        end
    end

    // Control registers; reset discards all stored words.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            ovf_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usedw_q    <= usedw_d;
            ovf_cnt_q  <= ovf_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    pixel_fifo_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
    ) u_ram (
        .clk_25  (clk_25),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

    assign rd_pix   = unpack_pixel(rd_word);
    assign x_o      = rd_pix.x;
    assign y_o      = rd_pix.y;
    assign red_o    = rd_pix.r;
    assign green_o  = rd_pix.g;
    assign blue_o   = rd_pix.b;
    assign rd_valid = rd_valid_q;
    assign usedw    = usedw_q;
    assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_pixel_burst_fifo.sv
// Directed bench for pixel_burst_fifo with a queue of expected read-out words.
module tb_pixel_burst_fifo;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic        wrreq;
    logic [9:0]  x_i, y_i;
    logic [7:0]  red_i, green_i, blue_i;
    logic        rdreq;
    logic        rd_valid;
    logic [9:0]  x_o, y_o;
    logic [7:0]  red_o, green_o, blue_o;
    logic [6:0]  usedw;
    logic        empty, full, burst_rdy;
    logic [15:0] ovf_cnt;

    int tests = 0;
    int fails = 0;
    logic [43:0] expq [$];
    logic [43:0] exp_w;

    pixel_burst_fifo #(.ADDR_W(6), .BURST_LEN(8)) dut (
        .clk_25(clk_25), .reset(reset), .wrreq(wrreq),
        .x_i(x_i), .y_i(y_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
        .rdreq(rdreq), .rd_valid(rd_valid),
        .x_o(x_o), .y_o(y_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .usedw(usedw), .empty(empty), .full(full), .burst_rdy(burst_rdy),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk_25 = ~clk_25;

    // Word that the bench writes for index k, in read-out field order {x,y,R,G,B}.
    function automatic logic [43:0] pat(input int k);
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        x = 10'(k * 3 + 1);
        y = 10'(k + 100);
        r = 8'(k);
        g = ~8'(k);
        b = 8'(k) ^ 8'h5A;
        return {x, y, r, g, b};
    endfunction

    function automatic logic [43:0] obs_word();
        return {x_o, y_o, red_o, green_o, blue_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    // One clock with the given write/read requests; sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [43:0] word, input logic r);
        wrreq   = w;
        rdreq   = r;
        x_i     = word[43:34];
        y_i     = word[33:24];
        red_i   = word[23:16];
        green_i = word[15:8];
        blue_i  = word[7:0];
        step();
        wrreq = 1'b0;
        rdreq = 1'b0;
    endtask

    task automatic wr(input int k);
        cyc(1'b1, pat(k), 1'b0);
        expq.push_back(pat(k));
    endtask

    task automatic rd_chk(input string tag);
        cyc(1'b0, '0, 1'b1);
        exp_w = expq.pop_front();
        chk({tag, "_vld"}, 64'(rd_valid), 64'd1);
        chk({tag, "_data"}, 64'(obs_word()), 64'(exp_w));
    endtask

    initial begin
        reset = 1'b1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        x_i = '0; y_i = '0; red_i = '0; green_i = '0; blue_i = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // 1: reset state
        chk("rst_usedw", 64'(usedw), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_burst", 64'(burst_rdy), 64'd0);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);
        chk("rst_vld", 64'(rd_valid), 64'd0);
        chk("rst_data", 64'(obs_word()), 64'd0);

        // 2: single pixel round trip with literal expected fields
        cyc(1'b1, {10'd5, 10'd7, 8'h11, 8'h22, 8'h33}, 1'b0);
        chk("t2_usedw1", 64'(usedw), 64'd1);
        chk("t2_empty0", 64'(empty), 64'd0);
        cyc(1'b0, '0, 1'b1);
        chk("t2_vld", 64'(rd_valid), 64'd1);
        chk("t2_x", 64'(x_o), 64'd5);
        chk("t2_y", 64'(y_o), 64'd7);
        chk("t2_r", 64'(red_o), 64'h11);
        chk("t2_g", 64'(green_o), 64'h22);
        chk("t2_b", 64'(blue_o), 64'h33);
        chk("t2_usedw0", 64'(usedw), 64'd0);
        cyc(1'b0, '0, 1'b1);
        chk("t2_empty_rd_vld", 64'(rd_valid), 64'd0);
        chk("t2_hold_x", 64'(x_o), 64'd5);

        // 3: burst threshold and ordering
        for (int k = 0; k < 7; k++) wr(k);
        chk("t3_burst7", 64'(burst_rdy), 64'd0);
        chk("t3_usedw7", 64'(usedw), 64'd7);
        wr(7);
        chk("t3_burst8", 64'(burst_rdy), 64'd1);
        rd_chk("t3_rd0");
        chk("t3_burst_after_rd", 64'(burst_rdy), 64'd0);
        for (int k = 1; k < 8; k++) rd_chk("t3_rd");
        chk("t3_empty", 64'(empty), 64'd1);

        // 4: overflow, read-while-full drops the write, counter saturation
        for (int k = 100; k < 164; k++) wr(k);
        chk("t4_full", 64'(full), 64'd1);
        chk("t4_usedw64", 64'(usedw), 64'd64);
        chk("t4_ovf0", 64'(ovf_cnt), 64'd0);
        cyc(1'b1, pat(164), 1'b0);
        cyc(1'b1, pat(165), 1'b0);
        chk("t4_ovf2", 64'(ovf_cnt), 64'd2);
        chk("t4_usedw_hold", 64'(usedw), 64'd64);
        cyc(1'b1, pat(999), 1'b1);
        exp_w = expq.pop_front();
        chk("t4_rdfull_data", 64'(obs_word()), 64'(exp_w));
        chk("t4_rdfull_ovf3", 64'(ovf_cnt), 64'd3);
        chk("t4_rdfull_usedw", 64'(usedw), 64'd63);
        for (int k = 0; k < 63; k++) rd_chk("t4_drain");
        chk("t4_drained_empty", 64'(empty), 64'd1);
        cyc(1'b0, '0, 1'b1);
        chk("t4_no_extra", 64'(rd_valid), 64'd0);
        for (int k = 0; k < 64; k++) cyc(1'b1, pat(k), 1'b0);
        chk("t4_refull", 64'(full), 64'd1);
        wrreq = 1'b1;
        for (int k = 0; k < 65531; k++) @(posedge clk_25);
        #1;
        chk("t4_ovf_fffe", 64'(ovf_cnt), 64'hFFFE);
        @(posedge clk_25);
        #1;
        chk("t4_ovf_ffff", 64'(ovf_cnt), 64'hFFFF);
        for (int k = 0; k < 3; k++) @(posedge clk_25);
        #1;
        wrreq = 1'b0;
        chk("t4_ovf_sat", 64'(ovf_cnt), 64'hFFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_rst_ovf", 64'(ovf_cnt), 64'd0);
        chk("t4_rst_usedw", 64'(usedw), 64'd0);

        // 5: steady simultaneous read/write at usedw=10, pointers wrap
        for (int k = 200; k < 210; k++) wr(k);
        chk("t5_usedw10", 64'(usedw), 64'd10);
        for (int k = 210; k < 310; k++) begin
            cyc(1'b1, pat(k), 1'b1);
            expq.push_back(pat(k));
            exp_w = expq.pop_front();
            chk("t5_data", 64'(obs_word()), 64'(exp_w));
            chk("t5_usedw", 64'(usedw), 64'd10);
        end
        chk("t5_vld", 64'(rd_valid), 64'd1);

        // 6: reset mid-operation discards stored words
        for (int k = 310; k < 320; k++) wr(k);
        chk("t6_usedw20", 64'(usedw), 64'd20);
        reset = 1'b1;
        rdreq = 1'b1;
        step();
        reset = 1'b0;
        rdreq = 1'b0;
        expq.delete();
        chk("t6_usedw0", 64'(usedw), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_vld0", 64'(rd_valid), 64'd0);
        chk("t6_burst0", 64'(burst_rdy), 64'd0);
        cyc(1'b0, '0, 1'b1);
        chk("t6_rd_after_rst", 64'(rd_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
